// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command stream, APB3 bus and response stream bundle
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready, pslverr,
    input  rsp_ready,
    output cmd_ready,
    output psel, penable, pwrite, paddr, pwdata,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready, pslverr,
    output rsp_ready,
    input  cmd_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding APB3 requester with wait-state watchdog
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  apb_cmd_master_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // Outputs are registered, so the bus phase lags the state by one cycle:
  // SETUP raises psel, the first ACCESS cycle raises penable.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        psel_d  = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!penable_q) begin
          penable_d = 1'b1;
        end else if (bus.pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Last permitted wait state also failed: abort the transfer.
          cnt_d         = cnt_q + CNT_W'(1);
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master with a behavioural APB slave
module tb_apb_cmd_master;
  localparam int          AW        = 32;
  localparam int          DW        = 32;
  localparam int          TMO       = 16;
  localparam logic [31:0] MEM_LIMIT = 32'h0000_0100;
  localparam logic [31:0] ERR_DATA  = 32'hBAD0_0000;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          pen;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          cur_waits = 0;
  int          cur_hold = 0;
  int          wait_left = 0;
  int          pen_cnt = 0;
  int          hold_left = 0;
  logic        seen_valid = 1'b0;
  logic        waiting = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        s_err = 1'b0;
  logic        s_tmo = 1'b0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB slave: fixed wait states per transfer, error outside MEM_LIMIT
  initial begin
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (bus.psel && bus.penable && !preset) begin
        if (wait_left == 0) begin
          bus.pready = 1'b1;
          if (bus.paddr >= MEM_LIMIT) begin
            bus.pslverr = 1'b1;
            bus.prdata  = ERR_DATA;
          end else begin
            bus.pslverr = 1'b0;
            if (bus.pwrite) begin
              bus.prdata = $urandom;
              slave_mem[bus.paddr] = bus.pwdata;
            end else begin
              bus.prdata = slave_mem.exists(bus.paddr) ? slave_mem[bus.paddr] : 32'h0;
            end
          end
        end else begin
          wait_left--;
          bus.pready  = 1'b0;
          bus.pslverr = 1'($urandom_range(0, 1));
          bus.prdata  = $urandom;
        end
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = $urandom;
        wait_left   = cur_waits;
      end
    end
  end

  // Monitor: protocol checks, response hold-off and scoreboard pops
  initial begin
    exp_t e;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        pen_cnt = 0; seen_valid = 1'b0; waiting = 1'b0; bus.rsp_ready = 1'b0;
      end else begin
        if (bus.penable) begin
          check("penable_without_psel", bus.psel, 1);
          pen_cnt++;
        end
        if (bus.psel) begin
          if (sb_q.size() == 0) check("psel_while_idle", bus.psel, 0);
          else begin
            check("paddr", bus.paddr, sb_q[0].addr);
            check("pwrite", bus.pwrite, sb_q[0].write);
            if (sb_q[0].write) check("pwdata", bus.pwdata, sb_q[0].wdata);
          end
        end
        if (bus.rsp_valid) begin
          check("cmd_ready_in_resp", bus.cmd_ready, 0);
          check("psel_in_resp", bus.psel, 0);
          if (!seen_valid) begin
            seen_valid = 1'b1;
            hold_left  = cur_hold;
            if (sb_q.size() != 0) begin
              check("latency", cyc - accept_cyc, sb_q[0].lat);
              check("penable_cycles", pen_cnt, sb_q[0].pen);
            end
          end
          if (waiting) begin
            check("hold_rdata", bus.rsp_rdata, s_rdata);
            check("hold_err", bus.rsp_err, s_err);
            check("hold_timeout", bus.rsp_timeout, s_tmo);
          end
          s_rdata = bus.rsp_rdata; s_err = bus.rsp_err; s_tmo = bus.rsp_timeout;
          if (hold_left > 0) begin
            hold_left--;
            bus.rsp_ready = 1'b0;
            waiting = 1'b1;
          end else begin
            bus.rsp_ready = 1'b1;
            waiting = 1'b0;
            if (sb_q.size() == 0) check("rsp_unexpected", bus.rsp_valid, 0);
            else begin
              e = sb_q.pop_front();
              check("rsp_rdata", bus.rsp_rdata, e.rdata);
              check("rsp_err", bus.rsp_err, e.err);
              check("rsp_timeout", bus.rsp_timeout, e.tmo);
            end
            seen_valid = 1'b0;
            pen_cnt = 0;
          end
        end else begin
          bus.rsp_ready = 1'b0;
          waiting = 1'b0;
        end
      end
    end
  end

  function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits);
    exp_t e;
    e.write = wr; e.addr = addr; e.wdata = wdata;
    e.tmo   = (waits >= TMO);
    e.err   = e.tmo || (addr >= MEM_LIMIT);
    if (wr || e.tmo)         e.rdata = 32'h0;
    else if (addr >= MEM_LIMIT) e.rdata = ERR_DATA;
    else                     e.rdata = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
    if (wr && !e.err) model_mem[addr] = wdata;
    e.lat = e.tmo ? 2 + TMO : 3 + waits;
    e.pen = e.tmo ? TMO : waits + 1;
    return e;
  endfunction

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits);
    int bound;
    cur_waits = waits;
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    bound = 0;
    while (!bus.cmd_ready && bound < 50) begin
      @(negedge pclk);
      bound++;
    end
    accept_cyc = cyc + 1;
    if (!bus.cmd_ready) check("cmd_ready_wait", bus.cmd_ready, 1);
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom; bus.cmd_write = 1'($urandom_range(0, 1));
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input int hold);
    int bound;
    cur_hold = hold;
    sb_q.push_back(model(wr, addr, wdata, waits));
    issue(wr, addr, wdata, waits);
    bound = 0;
    while (sb_q.size() != 0 && bound < 100) begin
      @(negedge pclk);
      bound++;
    end
    if (sb_q.size() != 0) begin
      check("rsp_wait_queue", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    int bound;
    exp_t e;
    logic [31:0] addr;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    repeat (3) @(negedge pclk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    preset = 1'b0;

    do_cmd(1'b1, 32'h04, 32'hDEAD_BEEF, 0, 0);
    do_cmd(1'b0, 32'h04, 32'h0, 0, 0);
    do_cmd(1'b0, 32'h04, 32'h0, 3, 0);
    do_cmd(1'b1, 32'h1000, 32'h1234_5678, 0, 0);
    do_cmd(1'b0, 32'h1004, 32'h0, 1, 0);
    do_cmd(1'b0, 32'h08, 32'h0, 1000, 0);
    do_cmd(1'b1, 32'h08, 32'hA5A5_0001, TMO - 1, 0);
    do_cmd(1'b1, 32'h08, 32'h5A5A_0002, TMO, 0);
    do_cmd(1'b0, 32'h08, 32'h0, 0, 0);
    do_cmd(1'b0, 32'h04, 32'h0, 0, 5);
    do_cmd(1'b1, 32'h0C, 32'hCAFE_F00D, 2, 5);

    // Reset in the middle of a stalled access phase
    e = model(1'b0, 32'h0C, 32'h0, 1000);
    sb_q.push_back(e);
    issue(1'b0, 32'h0C, 32'h0, 1000);
    bound = 0;
    while (!bus.penable && bound < 20) begin
      @(negedge pclk);
      bound++;
    end
    check("reset_test_penable", bus.penable, 1);
    repeat (2) @(negedge pclk);
    preset = 1'b1;
    #1;
    sb_q.delete();
    check("midrst_psel", bus.psel, 0);
    check("midrst_penable", bus.penable, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    repeat (3) @(negedge pclk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    do_cmd(1'b0, 32'h0C, 32'h0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int r;
      int waits;
      r = $urandom_range(0, 9);
      if (r < 7)       waits = $urandom_range(0, 3);
      else if (r == 7) waits = TMO - 1;
      else if (r == 8) waits = TMO;
      else             waits = TMO + 3;
      if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      else                           addr = 32'($urandom_range(0, 63)) * 4;
      do_cmd(1'($urandom_range(0, 1)), addr, $urandom, waits, $urandom_range(0, 3));
    end

    repeat (5) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
